digit_stroke_seq: RTL
=====================

DIGIT_STROKE_SEQ -- requirements
Module: digit_stroke_seq

Interface
REQ-001 SHALL have parameter COORD_W, default 8: coordinate width in bits.
REQ-002 SHALL have parameter CELL_W, default 120: character cell width.
REQ-003 SHALL have parameter CELL_H, default 80: character cell height; must be even.
REQ-004 SHALL have parameters HOME_X and HOME_Y, default 0: pen park position.
REQ-005 SHALL use one clock and a synchronous, active-high reset. Ports, clock and reset first:
- clk  in  1  sole clock, rising edge
- rst  in  1  synchronous active-high reset
- start  in  1  job request
- digit  in  4  digit to draw
- org_x  in  COORD_W  cell left edge
- org_y  in  COORD_W  cell top edge
- seg_valid  out  1  segment presented
- seg_ready  in  1  downstream line drawer accepts
- start_x  out  COORD_W  segment start x
- start_y  out  COORD_W  segment start y
- end_x  out  COORD_W  segment end x
- end_y  out  COORD_W  segment end y
- pen_down  out  1  1 = draw, 0 = travel
- seg_idx  out  5  index of segment within job, from 0
- busy  out  1  job in progress
- done  out  1  one-cycle end-of-job pulse

Function
REQ-006 SHALL sample start, digit, org_x and org_y only in IDLE; start while busy=1 SHALL be ignored.
REQ-007 SHALL set busy=1 from the cycle after start is accepted until the done cycle inclusive.
REQ-008 SHALL compute the cell geometry modulo 2^COORD_W:
- L=org_x, R=org_x+CELL_W
- T=org_y, M=org_y+CELL_H/2, B=org_y+CELL_H
REQ-009 SHALL define the segments as: a (L,T)->(R,T); b (R,T)->(R,M); c (R,M)->(R,B); d (R,B)->(L,B); e (L,B)->(L,M); f (L,M)->(L,T); g (L,M)->(R,M).
REQ-010 SHALL use these segment masks:
- 0=abcdef, 1=bc, 2=abdeg, 3=abcdg, 4=bcfg
- 5=acdfg, 6=acdefg, 7=abc, 8=abcdefg, 9=abcdfg
- 10-15 = no segments
REQ-011 SHALL emit the lit segments in the order a,b,c,d,e,f,g, each with pen_down=1.
REQ-012 SHALL emit a pen_down=0 travel segment before each lit segment, from the tracked pen position to that segment's start, and SHALL skip it when the two points are equal.
REQ-013 SHALL, after the last lit segment, emit a pen_down=0 travel to (HOME_X,HOME_Y), skipped if the pen is already there.
REQ-014 SHALL update the tracked pen position to each segment's end on its handshake; the position SHALL be (HOME_X,HOME_Y) after reset.
REQ-015 SHALL complete a handshake on a cycle where seg_valid=1 and seg_ready=1.
REQ-016 SHALL hold all segment outputs and seg_idx stable while seg_valid=1 and seg_ready=0.
REQ-017 SHALL not deassert seg_valid without a handshake.
REQ-018 SHALL drive start_x, start_y, end_x, end_y, pen_down and seg_idx to 0 while seg_valid=0.
REQ-019 SHALL increment seg_idx by 1 per handshake within a job and restart it at 0 for each job.
REQ-020 SHALL assert the first seg_valid no later than 8 cycles after start is accepted, and each subsequent seg_valid no later than 8 cycles after the previous handshake.
REQ-021 SHALL pulse done for exactly 1 cycle, the cycle after the final handshake, then return to IDLE with busy=0.
REQ-022 SHALL, for an empty job (digit 10-15 with the pen at home), pulse done within 8 cycles of start acceptance and emit no segment.
REQ-023 SHALL implement the FSM states IDLE, SCAN (find the next segment or travel), EMIT (present and wait for handshake) and FINISH (done pulse).

Reset
REQ-024 SHALL, when rst=1 on a clock edge, enter IDLE and drive seg_valid, busy, done, pen_down, seg_idx and all coordinates to 0.
REQ-025 SHALL, on reset, set the tracked pen position to (HOME_X,HOME_Y).
REQ-026 SHALL let reset mid-job abort the job with no done pulse.
REQ-027 SHALL, when rst and start are both high on the same edge, apply reset and not accept start.

Verification
REQ-028 digit 0, org (60,40), seg_ready=1 -> exactly these 8 segments, then done once:
- up (0,0)->(60,40)
- (60,40)->(180,40), (180,40)->(180,80), (180,80)->(180,120)
- (180,120)->(60,120), (60,120)->(60,80), (60,80)->(60,40)
- up (60,40)->(0,0)
REQ-029 digit 8, org (0,0) -> exactly these 9 segments, with no initial travel:
- first segment is down (0,0)->(120,0)
- segments a..f, then up (0,0)->(0,40), then g (0,40)->(120,40)
- then up (120,40)->(0,0)
- seg_idx runs 0..8
REQ-030 digit 1, org (200,40) with wrap -> exactly these 4 segments:
- up (0,0)->(64,40)
- (64,40)->(64,80), (64,80)->(64,120)
- up (64,120)->(0,0)
REQ-031 digit 0 with seg_ready held low 5 cycles on each segment -> outputs stable while stalled, same sequence as REQ-028, one done.
REQ-032 digit 12 -> no seg_valid, done within 8 cycles; start pulsed while busy -> ignored, no second job.
REQ-033 rst during the 3rd segment of digit 8 -> next cycle all outputs 0, no done; a new digit 0 job then starts its travel from (0,0).

Source files
------------

// File: rtl/digit_stroke_seq.sv
// Seven-segment digit stroke sequencer: turns a digit and a cell origin into
// a stream of pen-up travel and pen-down stroke segments for a line drawer.
module digit_stroke_seq #(
  parameter int unsigned COORD_W = 8,
  parameter int unsigned CELL_W  = 120,
  parameter int unsigned CELL_H  = 80,
  parameter int unsigned HOME_X  = 0,
  parameter int unsigned HOME_Y  = 0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [3:0]         digit,
  input  logic [COORD_W-1:0] org_x,
  input  logic [COORD_W-1:0] org_y,
  output logic               seg_valid,
  input  logic               seg_ready,
  output logic [COORD_W-1:0] start_x,
  output logic [COORD_W-1:0] start_y,
  output logic [COORD_W-1:0] end_x,
  output logic [COORD_W-1:0] end_y,
  output logic               pen_down,
  output logic [4:0]         seg_idx,
  output logic               busy,
  output logic               done
);

  localparam logic [COORD_W-1:0] HX  = COORD_W'(HOME_X);
  localparam logic [COORD_W-1:0] HY  = COORD_W'(HOME_Y);
  localparam logic [COORD_W-1:0] CW  = COORD_W'(CELL_W);
  localparam logic [COORD_W-1:0] CH  = COORD_W'(CELL_H);
  localparam logic [COORD_W-1:0] CH2 = COORD_W'(CELL_H / 2);

  typedef enum logic [1:0] {IDLE, SCAN, EMIT, FINISH} state_e;

  state_e             state_q, state_d;
  logic [6:0]         mask_q, mask_d;
  logic [COORD_W-1:0] l_q, l_d, r_q, r_d, t_q, t_d, m_q, m_d, b_q, b_d;
  logic [2:0]         ptr_q, ptr_d;
  logic [2:0]         cur_seg_q, cur_seg_d;
  logic               cur_lit_q, cur_lit_d;
  logic               cur_home_q, cur_home_d;
  logic [4:0]         cnt_q, cnt_d;
  logic [COORD_W-1:0] pen_x_q, pen_x_d, pen_y_q, pen_y_d;
  logic               seg_valid_q, seg_valid_d;
  logic [COORD_W-1:0] start_x_q, start_x_d, start_y_q, start_y_d;
  logic [COORD_W-1:0] end_x_q, end_x_d, end_y_q, end_y_d;
  logic               pen_down_q, pen_down_d;
  logic [4:0]         seg_idx_q, seg_idx_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic               found_c;
  logic [2:0]         next_c;
  logic [COORD_W-1:0] seg_sx_c, seg_sy_c, seg_ex_c, seg_ey_c;
  logic [7:0]         upto_c;
  logic               rem_c, hs_c, final_c, pen_home_c, pen_at_seg_c;

  // Segment masks, bit 0 = a ... bit 6 = g
  function automatic logic [6:0] digit_mask(input logic [3:0] d);
    case (d)
      4'd0:    return 7'h3F;
      4'd1:    return 7'h06;
      4'd2:    return 7'h5B;
      4'd3:    return 7'h4F;
      4'd4:    return 7'h66;
      4'd5:    return 7'h6D;
      4'd6:    return 7'h7D;
      4'd7:    return 7'h07;
      4'd8:    return 7'h7F;
      4'd9:    return 7'h6F;
      default: return 7'h00;
    endcase
  endfunction

  // Lowest lit segment at or after the scan pointer
  always_comb begin
    found_c = 1'b0;
    next_c  = 3'd0;
    for (int i = 6; i >= 0; i--) begin
      if (mask_q[i] && (3'(i) >= ptr_q)) begin
        found_c = 1'b1;
        next_c  = 3'(i);
      end
    end
  end

  // Endpoints of the candidate segment
  always_comb begin
    seg_sx_c = '0;
    seg_sy_c = '0;
    seg_ex_c = '0;
    seg_ey_c = '0;
    case (next_c)
      3'd0: begin seg_sx_c = l_q; seg_sy_c = t_q; seg_ex_c = r_q; seg_ey_c = t_q; end
      3'd1: begin seg_sx_c = r_q; seg_sy_c = t_q; seg_ex_c = r_q; seg_ey_c = m_q; end
      3'd2: begin seg_sx_c = r_q; seg_sy_c = m_q; seg_ex_c = r_q; seg_ey_c = b_q; end
      3'd3: begin seg_sx_c = r_q; seg_sy_c = b_q; seg_ex_c = l_q; seg_ey_c = b_q; end
      3'd4: begin seg_sx_c = l_q; seg_sy_c = b_q; seg_ex_c = l_q; seg_ey_c = m_q; end
      3'd5: begin seg_sx_c = l_q; seg_sy_c = m_q; seg_ex_c = l_q; seg_ey_c = t_q; end
      3'd6: begin seg_sx_c = l_q; seg_sy_c = m_q; seg_ex_c = r_q; seg_ey_c = m_q; end
      default: ;
    endcase
  end

  // Handshake and end-of-job detection; a lit stroke is final when nothing
  // lit follows it and it already ends at the park position
  always_comb begin
    hs_c         = seg_valid_q && seg_ready;
    pen_home_c   = (pen_x_q == HX) && (pen_y_q == HY);
    pen_at_seg_c = (pen_x_q == seg_sx_c) && (pen_y_q == seg_sy_c);
    upto_c       = (8'd2 << cur_seg_q) - 8'd1;
    rem_c        = |(mask_q & ~upto_c[6:0]);
    final_c      = cur_home_q ||
                   (cur_lit_q && !rem_c && (end_x_q == HX) && (end_y_q == HY));
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = SCAN;
      SCAN:    state_d = (found_c || !pen_home_c) ? EMIT : FINISH;
      EMIT:    if (hs_c) state_d = final_c ? FINISH : SCAN;
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath and output next values
  always_comb begin
    mask_d      = mask_q;
    l_d         = l_q;
    r_d         = r_q;
    t_d         = t_q;
    m_d         = m_q;
    b_d         = b_q;
    ptr_d       = ptr_q;
    cur_seg_d   = cur_seg_q;
    cur_lit_d   = cur_lit_q;
    cur_home_d  = cur_home_q;
    cnt_d       = cnt_q;
    pen_x_d     = pen_x_q;
    pen_y_d     = pen_y_q;
    seg_valid_d = seg_valid_q;
    start_x_d   = start_x_q;
    start_y_d   = start_y_q;
    end_x_d     = end_x_q;
    end_y_d     = end_y_q;
    pen_down_d  = pen_down_q;
    seg_idx_d   = seg_idx_q;
    busy_d      = (state_d != IDLE);
    done_d      = (state_d == FINISH);
    case (state_q)
      IDLE: begin
        if (start) begin
          mask_d = digit_mask(digit);
          l_d    = org_x;
          r_d    = org_x + CW;
          t_d    = org_y;
          m_d    = org_y + CH2;
          b_d    = org_y + CH;
          ptr_d  = 3'd0;
          cnt_d  = 5'd0;
        end
      end
      SCAN: begin
        if (found_c || !pen_home_c) begin
          seg_valid_d = 1'b1;
          seg_idx_d   = cnt_q;
          cur_seg_d   = next_c;
          cur_home_d  = !found_c;
          cur_lit_d   = 1'b0;
          pen_down_d  = 1'b0;
          start_x_d   = pen_x_q;
          start_y_d   = pen_y_q;
          end_x_d     = found_c ? seg_sx_c : HX;
          end_y_d     = found_c ? seg_sy_c : HY;
          if (found_c && pen_at_seg_c) begin
            cur_lit_d  = 1'b1;
            pen_down_d = 1'b1;
            start_x_d  = seg_sx_c;
            start_y_d  = seg_sy_c;
            end_x_d    = seg_ex_c;
            end_y_d    = seg_ey_c;
          end
        end
      end
      EMIT: begin
        if (hs_c) begin
          pen_x_d     = end_x_q;
          pen_y_d     = end_y_q;
          cnt_d       = cnt_q + 5'd1;
          if (cur_lit_q) ptr_d = cur_seg_q + 3'd1;
          seg_valid_d = 1'b0;
          start_x_d   = '0;
          start_y_d   = '0;
          end_x_d     = '0;
          end_y_d     = '0;
          pen_down_d  = 1'b0;
          seg_idx_d   = 5'd0;
        end
      end
      default: ;
    endcase
  end

  // Datapath and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      mask_q      <= '0;
      l_q         <= '0;
      r_q         <= '0;
      t_q         <= '0;
      m_q         <= '0;
      b_q         <= '0;
      ptr_q       <= '0;
      cur_seg_q   <= '0;
      cur_lit_q   <= 1'b0;
      cur_home_q  <= 1'b0;
      cnt_q       <= '0;
      pen_x_q     <= HX;
      pen_y_q     <= HY;
      seg_valid_q <= 1'b0;
      start_x_q   <= '0;
      start_y_q   <= '0;
      end_x_q     <= '0;
      end_y_q     <= '0;
      pen_down_q  <= 1'b0;
      seg_idx_q   <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      mask_q      <= mask_d;
      l_q         <= l_d;
      r_q         <= r_d;
      t_q         <= t_d;
      m_q         <= m_d;
      b_q         <= b_d;
      ptr_q       <= ptr_d;
      cur_seg_q   <= cur_seg_d;
      cur_lit_q   <= cur_lit_d;
      cur_home_q  <= cur_home_d;
      cnt_q       <= cnt_d;
      pen_x_q     <= pen_x_d;
      pen_y_q     <= pen_y_d;
      seg_valid_q <= seg_valid_d;
      start_x_q   <= start_x_d;
      start_y_q   <= start_y_d;
      end_x_q     <= end_x_d;
      end_y_q     <= end_y_d;
      pen_down_q  <= pen_down_d;
      seg_idx_q   <= seg_idx_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign seg_valid = seg_valid_q;
  assign start_x   = start_x_q;
  assign start_y   = start_y_q;
  assign end_x     = end_x_q;
  assign end_y     = end_y_q;
  assign pen_down  = pen_down_q;
  assign seg_idx   = seg_idx_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule
